// File: rtl/usb_pkg.sv
// usb_pkg
// Shared types and constants for the USB serial transmit path.
//   bs_state_t        : bit stuffer FSM states
//   STUFF_LEN_DEFAULT : consecutive 1s that force a stuffed 0
//   USB_DATA_W        : width of the serial data path
//   STUFF_CNT_W       : width of the per-packet stuffed-bit counter
package usb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    STUFF = 2'd2
  } bs_state_t;

  localparam int STUFF_LEN_DEFAULT = 6;
  localparam int ONES_CNT_W_DEFAULT = 4;
  localparam int USB_DATA_W = 1;
  localparam int STUFF_CNT_W = 8;

  // Saturating increment so a pathological packet cannot wrap the count.
  function automatic logic [STUFF_CNT_W-1:0] sat_inc(input logic [STUFF_CNT_W-1:0] v);
    return (v == {STUFF_CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/bit_stuffer_if.sv
// bit_stuffer_if
// Serial stream bundle around the bit stuffer.
//   in_bit, in_valid  : serial packet+CRC stream from the CRC calculator
//   bs_ready          : stuffer accepts a bit this cycle
//   out_bit, out_valid: stuffed serial stream to the NRZI encoder
//   stuff_count       : stuffed bits in the current packet (BS_STUFF_CNT_EN only)
// Modports: master = upstream/downstream environment, slave = the stuffer.
interface bit_stuffer_if;

  logic in_bit;
  logic in_valid;
  logic bs_ready;
  logic out_bit;
  logic out_valid;
`ifdef BS_STUFF_CNT_EN
  logic [usb_pkg::STUFF_CNT_W-1:0] stuff_count;

  modport master (
    output in_bit, in_valid,
    input  bs_ready, out_bit, out_valid, stuff_count
  );

  modport slave (
    input  in_bit, in_valid,
    output bs_ready, out_bit, out_valid, stuff_count
  );
`else
  modport master (
    output in_bit, in_valid,
    input  bs_ready, out_bit, out_valid
  );

  modport slave (
    input  in_bit, in_valid,
    output bs_ready, out_bit, out_valid
  );
`endif

endinterface

// File: rtl/bit_stuffer_ones_counter.sv
// bs_ones_counter
// Run-length counter of consecutive accepted 1s.
//   clock, reset_n : clock, async active-low reset
//   clear          : restart the run (accepted 0, stuffed cycle, packet gap)
//   incr           : an accepted 1 extends the run
//   hit_next       : this increment completes a run of STUFF_LEN 1s
// The run is cleared on the stuffed cycle, so count never exceeds STUFF_LEN.
module bs_ones_counter
  import usb_pkg::*;
#(
  parameter int STUFF_LEN = STUFF_LEN_DEFAULT,
  parameter int CNT_W     = ONES_CNT_W_DEFAULT
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic incr,
  output logic hit_next
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (incr) begin
      count <= count + 1'b1;
    end
  end

  // Looks one increment ahead so the FSM can enter STUFF on the same edge
  // that accepts the last 1 of the run.
  assign hit_next = incr && (count == CNT_W'(STUFF_LEN - 1));

endmodule

// File: rtl/bit_stuffer.sv
// bit_stuffer
// USB transmit bit stuffer between the CRC calculator and the NRZI encoder.
// Inserts a 0 after every STUFF_LEN consecutive 1s, holding off upstream
// for the one stuffed cycle.
//   clock    : system clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : bit_stuffer_if.slave (in_bit/in_valid/bs_ready in,
//              out_bit/out_valid out, stuff_count when enabled)
// Optional feature macro: BS_STUFF_CNT_EN adds the 8-bit saturating
// per-packet stuffed-bit counter on bus.stuff_count.
//
// state | meaning
// IDLE  | between packets, ready; first valid bit starts a packet
// SEND  | passing bits through, counting consecutive 1s
// STUFF | run of STUFF_LEN 1s completed; emit a 0, upstream held off
module bit_stuffer
  import usb_pkg::*;
#(
  parameter int STUFF_LEN = STUFF_LEN_DEFAULT,
  parameter int CNT_W     = ONES_CNT_W_DEFAULT
) (
  input  logic          clock,
  input  logic          reset_n,
  bit_stuffer_if.slave  bus
);

  bs_state_t state;
  logic      out_bit_q;
  logic      out_valid_q;
  logic      accept;
  logic      cnt_clear;
  logic      cnt_incr;
  logic      hit_next;
`ifdef BS_STUFF_CNT_EN
  logic [STUFF_CNT_W-1:0] stuff_count_q;
`endif

  // Moore ready: no combinational path from in_valid.
  assign bus.bs_ready  = (state != STUFF);
  assign bus.out_bit   = out_bit_q;
  assign bus.out_valid = out_valid_q;
`ifdef BS_STUFF_CNT_EN
  assign bus.stuff_count = stuff_count_q;
`endif

  assign accept = bus.in_valid && (state != STUFF);

  // Any cycle without an accepted 1 ends the run: accepted 0, the stuffed
  // cycle and packet gaps all restart counting.
  always_comb begin
    cnt_clear = 1'b0;
    cnt_incr  = 1'b0;
    if (accept && bus.in_bit) begin
      cnt_incr = 1'b1;
    end else begin
      cnt_clear = 1'b1;
    end
  end

  bs_ones_counter #(
    .STUFF_LEN (STUFF_LEN),
    .CNT_W     (CNT_W)
  ) u_ones_counter (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    (cnt_clear),
    .incr     (cnt_incr),
    .hit_next (hit_next)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      out_bit_q   <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef BS_STUFF_CNT_EN
      stuff_count_q <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            out_bit_q   <= bus.in_bit;
            out_valid_q <= 1'b1;
            state       <= SEND;
`ifdef BS_STUFF_CNT_EN
            stuff_count_q <= '0;
`endif
          end else begin
            out_valid_q <= 1'b0;
          end
        end
        SEND: begin
          if (bus.in_valid) begin
            out_bit_q   <= bus.in_bit;
            out_valid_q <= 1'b1;
            if (hit_next) begin
              state <= STUFF;
            end
          end else begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        STUFF: begin
          // The stuffed 0 goes out even if the packet has just ended.
          out_bit_q   <= 1'b0;
          out_valid_q <= 1'b1;
          state       <= bus.in_valid ? SEND : IDLE;
`ifdef BS_STUFF_CNT_EN
          stuff_count_q <= sat_inc(stuff_count_q);
`endif
        end
        default: begin
          out_valid_q <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_stuffer.sv
module tb_bit_stuffer;

  localparam int SL = 6;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  bit_stuffer_if bus ();

  bit_stuffer #(
    .STUFF_LEN (SL),
    .CNT_W     (4)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  bit exp_q[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every presented output bit is popped and compared.
  always @(negedge clock) begin
    if (reset_n === 1'b1 && bus.out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got bit %0b with no expected bit at %0t", bus.out_bit, $time);
      end else begin
        check("out_bit", bus.out_bit, exp_q.pop_front());
      end
    end
  end

  // Reference: plain run-length rule over the whole packet.
  task automatic model(input bit pkt[$], output int nstuff, output bit last_stuff);
    int run;
    run = 0;
    nstuff = 0;
    last_stuff = 0;
    foreach (pkt[i]) begin
      exp_q.push_back(pkt[i]);
      last_stuff = 0;
      if (pkt[i]) begin
        run++;
        if (run == SL) begin
          exp_q.push_back(1'b0);
          nstuff++;
          run = 0;
          last_stuff = 1;
        end
      end else begin
        run = 0;
      end
    end
  endtask

  // Drives bits with in_valid held high; caller is at posedge+1.
  task automatic drive_bits(input bit pkt[$], output int lows);
    lows = 0;
    foreach (pkt[i]) begin
      bus.in_bit   = pkt[i];
      bus.in_valid = 1'b1;
      for (int t = 0; t < 3 && bus.bs_ready !== 1'b1; t++) begin
        lows++;
        @(posedge clock); #1;
        check("valid_in_stuff_cycle", bus.out_valid, 1);
      end
      check("ready_before_accept", bus.bs_ready, 1);
      @(posedge clock); #1;
      check("out_valid_stream", bus.out_valid, 1);
    end
  endtask

  task automatic send_packet(input bit pkt[$], input int gap);
    int  nstuff;
    bit  last_stuff;
    int  lows;
    model(pkt, nstuff, last_stuff);
    drive_bits(pkt, lows);
    check("ready_low_cycles", lows, nstuff - int'(last_stuff));
    check("end_ready", bus.bs_ready, !last_stuff);
    bus.in_valid = 1'b0;
    bus.in_bit   = 1'($urandom);
    for (int g = 0; g < gap; g++) begin
      @(posedge clock); #1;
      check("gap_valid", bus.out_valid, (g == 0 && last_stuff));
    end
`ifdef BS_STUFF_CNT_EN
    check("stuff_count", bus.stuff_count, (nstuff > 255) ? 255 : nstuff);
`endif
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit p[$];
    int lows;
    int nstuff;
    bit last_stuff;

    bus.in_bit   = 1'b0;
    bus.in_valid = 1'b0;
    reset_n      = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_out_bit", bus.out_bit, 0);
    check("reset_ready", bus.bs_ready, 1);
`ifdef BS_STUFF_CNT_EN
    check("reset_stuff_count", bus.stuff_count, 0);
`endif
    reset_n = 1'b1;
    @(posedge clock); #1;

    p = '{1, 1, 1, 1, 1, 1, 1, 0};
    send_packet(p, 2);

    p.delete();
    for (int i = 0; i < 12; i++) p.push_back(1'b1);
    send_packet(p, 3);

    p = '{1, 0, 1, 1, 0, 1, 1, 1, 1, 1};
    send_packet(p, 2);

    p = '{1, 1, 1};
    send_packet(p, 2);
    send_packet(p, 2);

    p = '{0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 1, 1, 0, 0, 0, 0, 1};
    send_packet(p, 2);

    // Reset while in STUFF: the pending stuffed 0 must never appear.
    p = '{1, 1, 1, 1, 1, 1};
    model(p, nstuff, last_stuff);
    drive_bits(p, lows);
    check("mid_ready_low", bus.bs_ready, 0);
    @(negedge clock); #1;
    check("pending_stuff", exp_q.size(), 1);
    exp_q.delete();
    reset_n      = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check("async_rst_valid", bus.out_valid, 0);
    check("async_rst_bit", bus.out_bit, 0);
    check("async_rst_ready", bus.bs_ready, 1);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;
    send_packet(p, 2);

    for (int k = 0; k < 40; k++) begin
      int len;
      p.delete();
      len = $urandom_range(1, 40);
      for (int j = 0; j < len; j++) p.push_back($urandom_range(0, 9) < 8);
      send_packet(p, $urandom_range(1, 3));
    end

    repeat (3) @(posedge clock);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bit_stuffer.md
Name: bit_stuffer

Overview:
- Serial USB bit stuffer sitting directly downstream of the CRC calculator; consumes its serial packet+CRC stream through the in_valid/bs_ready handshake.
- Inserts a 0 after every STUFF_LEN consecutive 1s and throttles upstream with bs_ready for the stuffed cycle.
- Output is a registered serial stream with valid, feeding the NRZI encoder.

Parameters:
- STUFF_LEN, 6, number of consecutive 1s that triggers insertion of one 0 (legal range 2..15).
- CNT_W, 4, width of the ones counter; must hold STUFF_LEN.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_bit  in  1  serial data bit from the CRC calculator.
- in_valid  in  1  high for the whole packet, including upstream pauses; low between packets.
- bs_ready  out  1  high when a bit is accepted this cycle; low only in the STUFF state.
- out_bit  out  1  registered stuffed serial bit to the NRZI encoder.
- out_valid  out  1  registered; out_bit is meaningful.
- stuff_count  out  8  number of stuffed bits in the current packet; present only with BS_STUFF_CNT_EN.

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-low (clock, reset_n).
- Reset values: state=IDLE, ones_cnt=0, out_bit=0, out_valid=0, stuff_count=0. bs_ready is Moore-decoded from state, so it is 1 in IDLE.
- Acceptance: a bit is accepted when in_valid && bs_ready. bs_ready is a function of state only, with no combinational path from in_valid.
- Latency: an accepted bit appears on out_bit with out_valid=1 at the next rising edge (1 cycle).
- States:
  - IDLE: bs_ready=1. On in_valid: accept the bit and go to SEND. stuff_count is cleared at this packet start.
  - SEND: bs_ready=1.
    - Accepted 1: ones_cnt++. If the new ones_cnt==STUFF_LEN, go to STUFF.
    - Accepted 0: ones_cnt=0.
    - in_valid low: out_valid=0 next edge, ones_cnt=0, go to IDLE (packet boundary).
  - STUFF: bs_ready=0, no bit accepted. Next edge: out_bit=0, out_valid=1, ones_cnt=0, go to SEND if in_valid else IDLE. stuff_count increments, saturating at 255.
- Stuffing at the end of a packet is mandatory. If in_valid drops while in STUFF, the stuffed 0 is still emitted.
- ones_cnt never exceeds STUFF_LEN. Counting restarts at 0 every packet, so 1s never carry across an in_valid low gap.
- Stream continuity: with in_valid held high, out_valid is high every cycle including the stuffed cycle. No bubbles are introduced.
- Reset mid-operation (any state): immediate return to reset values. A partially sent packet is discarded and no stuffed bit is emitted.
- Simultaneous events: in STUFF, any in_bit presented is ignored. Upstream must hold it, which the CRC calculator does by pausing on ~bs_ready.

Optional Feature:
- Macro BS_STUFF_CNT_EN.
- Defined: stuff_count port and 8-bit saturating counter exist. The counter clears on the IDLE->SEND transition and increments on each STUFF exit. The value holds after the packet ends until the next packet starts.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package usb_pkg holds:
  - bs_state_t enum {IDLE, SEND, STUFF};
  - localparam STUFF_LEN_DEFAULT=6;
  - shared USB_DATA_W-style width constants.
- One natural sub-module, bs_ones_counter: ones counter with clear/increment/hit(==STUFF_LEN) output. The FSM and output register stay in bit_stuffer.

Test Plan:
1. in_valid=1, bits 1,1,1,1,1,1,1,0 -> out 1,1,1,1,1,1,0,1,0 (9 bits). bs_ready low exactly 1 cycle, the cycle after the 6th 1 is accepted. out_valid is continuous for 9 cycles.
2. 12 consecutive 1s then in_valid=0 -> 14 output bits: six 1s, 0, six 1s, 0. The final stuffed 0 is emitted after in_valid falls. stuff_count=2 with BS_STUFF_CNT_EN.
3. Bits 1,0,1,1,0,1,1,1,1,1 (max run 5) -> output identical to input, bs_ready never low, stuff_count=0.
4. Three 1s, in_valid low 2 cycles, then three 1s -> no stuffing, ones_cnt restarts, out_valid low for the 2 gap cycles.
5. Reset pulse asserted while in STUFF -> out_valid=0, out_bit=0, bs_ready=1 asynchronously. A following packet of six 1s stuffs after the 6th bit, not earlier.
6. Drive the CRC calculator with the 19-bit token 0100_0000101_11100001 into bit_stuffer -> 0 stuffs, output equals the CRC calculator stream delayed by 1 cycle.
